stage3_mem_stage: RTL and testbench
===================================

// Module: stage3_mem_stage
// PURPOSE
// - Memory stage of the 3-stage RV32 pipeline, between execute and writeback.
// - Latches execute results and runs load/store data-bus transactions, with alignment and sign extension.
// - Sources the rd_mem/rd_mem_data/regWEN/load view used by the forwarding unit.
// - Produces registered writeback and a stall back to fetch/execute.
// PARAMETERS
// - BUS_TIMEOUT  255  max cycles in WAIT before abort; 0 disables timeout
// PORTS
// - CLK            in   1   clock, rising edge
// - nRST           in   1   asynchronous active-low reset
// - ex_valid       in   1   execute offers an instruction this cycle
// - ex_rd          in   5   destination register
// - ex_regWEN      in   1   instruction writes rd
// - ex_load        in   1   instruction is a load
// - ex_store       in   1   instruction is a store
// - ex_funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
// - ex_alu_res     in   32  ALU result / effective address
// - ex_store_data  in   32  rs2 value for stores
// - flush          in   1   kill instruction held in stage
// - mem_stall      out  1   upstream must hold; stage not accepting
// - rd_mem         out  5   rd of held instr (forwarding)
// - rd_mem_data    out  32  ALU result of held instr (forwarding)
// - regWEN         out  1   held instr valid and writes rd
// - load           out  1   held instr valid and is a load
// - dbus_addr      out  32  word-aligned address ({addr[31:2],2'b00})
// - dbus_ren       out  1   read request
// - dbus_wen       out  1   write request
// - dbus_wdata     out  32  store data, lane-shifted
// - dbus_byte_en   out  4   byte lanes
// - dbus_rdata     in   32  read data, valid when dbus_busy=0
// - dbus_busy      in   1   1 = transaction not complete
// - wb_we          out  1   writeback strobe, 1 cycle
// - wb_rd          out  5   writeback register
// - wb_data        out  32  writeback value
// - misaligned     out  1   1-cycle pulse, misaligned access dropped
// - bus_err        out  1   1-cycle pulse, transaction timed out
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, held entry invalid, timeout counter 0.
// - Capture: at the edge where mem_stall=0, the entry loads the ex_* fields; valid <= ex_valid & ~flush.
// - Forwarding: regWEN=valid&regWEN_r, load=valid&load_r, rd_mem=rd_r, rd_mem_data=alu_res_r (all combinational from entry).
// - States:
//   - IDLE: entry empty or non-memory.
//   - WAIT: bus request outstanding.
//   - DRAIN: flushed but bus transaction still outstanding.
// - IDLE:
//   - valid non-mem entry retires next edge: wb_we=regWEN_r, wb_data=alu_res_r, rd_r.
//   - valid mem entry that is aligned: request asserted in the first held cycle; if dbus_busy=0, retires that edge, else ->WAIT.
// - WAIT: hold ren/wen/addr/wdata/byte_en stable.
//   - busy=0: retire, ->IDLE.
//   - flush: ->DRAIN.
//   - count reaches BUS_TIMEOUT: drop request, pulse bus_err, no wb, ->IDLE.
// - DRAIN: hold request until busy=0, then ->IDLE, no writeback; a timeout in DRAIN also ->IDLE with bus_err.
// - flush in IDLE, or in the first cycle with busy=0: entry invalidated, no wb, no bus_err.
// - mem_stall = valid & mem & ~(done this cycle), where done is busy=0 or timeout; mem_stall is also 1 in DRAIN.
// - Non-mem latency: wb one cycle after capture. Load latency: wb one cycle after busy=0.
// - Alignment: H needs addr[0]=0; W needs addr[1:0]=0.
//   - Violation: no bus request, misaligned pulse, no wb, retire in one cycle.
// - Store lanes:
//   - SB: byte_en=1<<a, wdata=data[7:0]<<8a.
//   - SH: byte_en=3<<a, wdata=data[15:0]<<8a.
//   - SW: byte_en=F.
// - Loads: byte_en per width (as stores); rdata>>8a; LB/LH sign-extend; LBU/LHU zero-extend.
// - Stores never assert wb_we; wb_we is a 1-cycle pulse; wb_rd/wb_data hold last value.
// - Writes to rd=0 are forwarded as given; the forwarding unit/regfile ignore x0.
// - Async reset mid-WAIT: request drops immediately; no wb, no bus_err.
// TESTING
// - ADD rd=5 res=0x1234 -> regWEN=1 rd_mem=5 next cycle; wb_we=1 rd=5 data=0x1234 cycle after.
// - LB addr=0x103, busy 3 cycles, rdata=0x80000000 -> ren held 3 cycles, byte_en=8, mem_stall=1; wb_data=0xFFFFFF80.
// - SH addr=0x102 data=0xABCD -> wen, byte_en=C, wdata=0xABCD0000, dbus_addr=0x100, no wb_we.
// - LW addr=0x101 -> misaligned pulse, no ren, no wb, no stall.
// - LW, busy held forever, BUS_TIMEOUT=4 -> bus_err after 4 WAIT cycles, ren drops, no wb, stall releases.
// - flush in WAIT of LHU -> DRAIN; busy=0 two cycles later -> no wb; back-to-back ADD then accepted.

Source files
------------

// File: rtl/stage3_mem_stage.sv
// Memory stage of the 3-stage RV32 pipeline: holds the execute result, runs the
// load/store bus handshake with lane alignment, and feeds forwarding and writeback.
module stage3_mem_stage #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regWEN,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_store_data,
    input  logic        flush,
    output logic        mem_stall,
    output logic [4:0]  rd_mem,
    output logic [31:0] rd_mem_data,
    output logic        regWEN,
    output logic        load,
    output logic [31:0] dbus_addr,
    output logic        dbus_ren,
    output logic        dbus_wen,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_byte_en,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_busy,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_err
);

    localparam int CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((BUS_TIMEOUT > 0) ? (BUS_TIMEOUT - 1) : 0);
    localparam logic TO_EN = (BUS_TIMEOUT > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Byte lanes touched by an access of size sz (funct3[1:0]) at byte offset a.
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   lane_mask = 4'b0001 << a;
            2'b01:   lane_mask = 4'b0011 << a;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [1:0] a,
                                                input logic [31:0] data);
        case (sz)
            2'b00:   store_lanes = {24'd0, data[7:0]} << {a, 3'b000};
            2'b01:   store_lanes = {16'd0, data[15:0]} << {a, 3'b000};
            default: store_lanes = data;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~a[0];
            default: is_aligned = (a == 2'b00);
        endcase
    endfunction

    // Shift the addressed lane down to bit 0 and extend according to funct3.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {a, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_extend = {24'd0, sh[7:0]};
            3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_extend = {16'd0, sh[15:0]};
            default: load_extend = rdata;
        endcase
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             valid_r;
    logic [4:0]       rd_r;
    logic             regwen_r;
    logic             load_r;
    logic             store_r;
    logic [2:0]       funct3_r;
    logic [31:0]      alu_res_r;
    logic [31:0]      store_data_r;

    logic             is_mem_s;
    logic             aligned_s;
    logic             timeout_s;
    logic             req_s;
    logic             done_s;
    logic             stall_s;
    logic [31:0]      load_val_s;

    // Decode of the held entry: bus request, completion and stall.
    always_comb begin
        is_mem_s   = load_r | store_r;
        aligned_s  = is_aligned(funct3_r[1:0], alu_res_r[1:0]);
        load_val_s = load_extend(funct3_r, alu_res_r[1:0], dbus_rdata);
        if (TO_EN && (state_r != ST_IDLE) && dbus_busy && (cnt_r == TO_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        case (state_r)
            ST_IDLE:  req_s = valid_r & is_mem_s & aligned_s;
            ST_WAIT:  req_s = 1'b1;
            ST_DRAIN: req_s = 1'b1;
            default:  req_s = 1'b0;
        endcase
        done_s = ~dbus_busy | timeout_s;
        if (state_r == ST_DRAIN) begin
            stall_s = 1'b1;
        end else begin
            stall_s = valid_r & is_mem_s & aligned_s & ~done_s;
        end
    end

    // Bus drive is derived from the held entry so it drops at once on reset.
    always_comb begin
        if (req_s) begin
            dbus_addr    = {alu_res_r[31:2], 2'b00};
            dbus_ren     = load_r;
            dbus_wen     = store_r;
            dbus_byte_en = lane_mask(funct3_r[1:0], alu_res_r[1:0]);
            dbus_wdata   = store_r ? store_lanes(funct3_r[1:0], alu_res_r[1:0], store_data_r)
                                   : 32'd0;
        end else begin
            dbus_addr    = 32'd0;
            dbus_ren     = 1'b0;
            dbus_wen     = 1'b0;
            dbus_byte_en = 4'd0;
            dbus_wdata   = 32'd0;
        end
    end

    assign mem_stall   = stall_s;
    assign regWEN      = valid_r & regwen_r;
    assign load        = valid_r & load_r;
    assign rd_mem      = rd_r;
    assign rd_mem_data = alu_res_r;

    // Pipeline entry: capture when not stalled; a flush while stalled only invalidates it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_r      <= 1'b0;
            rd_r         <= 5'd0;
            regwen_r     <= 1'b0;
            load_r       <= 1'b0;
            store_r      <= 1'b0;
            funct3_r     <= 3'd0;
            alu_res_r    <= 32'd0;
            store_data_r <= 32'd0;
        end else if (!stall_s) begin
            valid_r      <= ex_valid & ~flush;
            rd_r         <= ex_rd;
            regwen_r     <= ex_regWEN;
            load_r       <= ex_load;
            store_r      <= ex_store;
            funct3_r     <= ex_funct3;
            alu_res_r    <= ex_alu_res;
            store_data_r <= ex_store_data;
        end else if (flush) begin
            valid_r      <= 1'b0;
        end else begin
            valid_r      <= valid_r;
        end
    end

    // Bus FSM, timeout counter and registered writeback/status pulses.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            wb_we      <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (valid_r && !flush) begin
                        if (!is_mem_s) begin
                            if (regwen_r) begin
                                wb_we   <= 1'b1;
                                wb_rd   <= rd_r;
                                wb_data <= alu_res_r;
                            end
                        end else if (!aligned_s) begin
                            misaligned <= 1'b1;
                        end else if (dbus_busy) begin
                            state_r <= ST_WAIT;
                        end else if (load_r && regwen_r) begin
                            wb_we   <= 1'b1;
                            wb_rd   <= rd_r;
                            wb_data <= load_val_s;
                        end
                    end else if (valid_r && is_mem_s && aligned_s && dbus_busy) begin
                        // Flushed with the request already on the bus: see it through.
                        state_r <= ST_DRAIN;
                    end
                end
                ST_WAIT: begin
                    if (!dbus_busy) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                        if (!flush && load_r && regwen_r) begin
                            wb_we   <= 1'b1;
                            wb_rd   <= rd_r;
                            wb_data <= load_val_s;
                        end
                    end else if (timeout_s) begin
                        bus_err <= 1'b1;
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (flush) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!dbus_busy) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else if (timeout_s) begin
                        bus_err <= 1'b1;
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage3_mem_stage.sv
// Directed bench for stage3_mem_stage: single-cycle vector table plus
// hand-written multi-cycle sequences (wait states, timeout, drain, reset).
module tb_stage3_mem_stage;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_regWEN = 1'b0;
    logic        ex_load = 1'b0;
    logic        ex_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_alu_res = 32'd0;
    logic [31:0] ex_store_data = 32'd0;
    logic        flush = 1'b0;
    logic        mem_stall;
    logic [4:0]  rd_mem;
    logic [31:0] rd_mem_data;
    logic        regWEN;
    logic        load;
    logic [31:0] dbus_addr;
    logic        dbus_ren;
    logic        dbus_wen;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_byte_en;
    logic [31:0] dbus_rdata = 32'd0;
    logic        dbus_busy = 1'b0;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;
    logic        bus_err;

    stage3_mem_stage #(.BUS_TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regWEN(ex_regWEN),
        .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3), .ex_alu_res(ex_alu_res),
        .ex_store_data(ex_store_data), .flush(flush), .mem_stall(mem_stall), .rd_mem(rd_mem),
        .rd_mem_data(rd_mem_data), .regWEN(regWEN), .load(load), .dbus_addr(dbus_addr),
        .dbus_ren(dbus_ren), .dbus_wen(dbus_wen), .dbus_wdata(dbus_wdata),
        .dbus_byte_en(dbus_byte_en), .dbus_rdata(dbus_rdata), .dbus_busy(dbus_busy),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  rd;
        logic        rw, ld, st;
        logic [2:0]  f3;
        logic [31:0] alu, sd, rdata;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_mis, e_wb;
        logic [31:0] e_wbd;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_data = 32'd0;
    vec_t        vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                         input logic st, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sd);
        ex_valid = v; ex_rd = rd; ex_regWEN = rw; ex_load = ld; ex_store = st;
        ex_funct3 = f3; ex_alu_res = alu; ex_store_data = sd;
    endtask

    task automatic chk_wb(input string name, input logic exp_we);
        chk1({name, "_wb_we"}, wb_we, exp_we);
        chk({name, "_wb_rd"}, 32'(wb_rd), 32'(m_rd));
        chk({name, "_wb_data"}, wb_data, m_data);
    endtask

    function automatic vec_t mk(input logic [4:0] rd, input logic rw, input logic ld,
                                input logic st, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] sd, input logic [31:0] rdata,
                                input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic [3:0] e_be,
                                input logic e_mis, input logic e_wb, input logic [31:0] e_wbd);
        vec_t v;
        v.rd = rd; v.rw = rw; v.ld = ld; v.st = st; v.f3 = f3; v.alu = alu; v.sd = sd;
        v.rdata = rdata; v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_be = e_be; v.e_mis = e_mis; v.e_wb = e_wb; v.e_wbd = e_wbd;
        return v;
    endfunction

    initial begin
        //            rd  rw ld st f3      alu           sd            rdata         ren wen addr          wdata         be       mis wb wbd
        vecs[0]  = mk(5'd5, 1, 0, 0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 1, 32'h0000_1234);
        vecs[1]  = mk(5'd0, 0, 0, 1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0,        0, 1, 32'h0000_0100, 32'hABCD_0000, 4'hC, 0, 0, 32'h0);
        vecs[2]  = mk(5'd8, 1, 1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0);
        vecs[3]  = mk(5'd3, 1, 1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h8000_0000, 1, 0, 32'h0000_0100, 32'h0,        4'h8, 0, 1, 32'hFFFF_FF80);
        vecs[4]  = mk(5'd4, 1, 1, 0, 3'b100, 32'h0000_0101, 32'h0,        32'h0000_F500, 1, 0, 32'h0000_0100, 32'h0,        4'h2, 0, 1, 32'h0000_00F5);
        vecs[5]  = mk(5'd6, 1, 1, 0, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_0000, 1, 0, 32'h0000_0200, 32'h0,        4'hC, 0, 1, 32'hFFFF_8001);
        vecs[6]  = mk(5'd7, 1, 1, 0, 3'b101, 32'h0000_0200, 32'h0,        32'h1234_9ABC, 1, 0, 32'h0000_0200, 32'h0,        4'h3, 0, 1, 32'h0000_9ABC);
        vecs[7]  = mk(5'd9, 1, 1, 0, 3'b010, 32'h0000_0300, 32'h0,        32'hDEAD_BEEF, 1, 0, 32'h0000_0300, 32'h0,        4'hF, 0, 1, 32'hDEAD_BEEF);
        vecs[8]  = mk(5'd0, 0, 0, 1, 3'b000, 32'h0000_0401, 32'h1122_3344, 32'h0,        0, 1, 32'h0000_0400, 32'h0000_4400, 4'h2, 0, 0, 32'h0);
        vecs[9]  = mk(5'd0, 0, 0, 1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 32'h0,        0, 1, 32'h0000_0404, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0);
        vecs[10] = mk(5'd2, 1, 1, 0, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0);
        vecs[11] = mk(5'd0, 1, 0, 0, 3'b000, 32'h0000_0055, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 1, 32'h0000_0055);
        vecs[12] = mk(5'd7, 0, 0, 0, 3'b000, 32'h0000_0099, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0);
        vecs[13] = mk(5'd0, 0, 0, 1, 3'b010, 32'h0000_0402, 32'h5555_AAAA, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 32'h0);
        vecs[14] = mk(5'd1, 1, 1, 0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 1, 0, 32'h0000_0100, 32'h0,        4'h1, 0, 1, 32'h0000_007F);

        // Reset state
        #3;
        chk1("rst_stall", mem_stall, 1'b0);
        chk1("rst_regWEN", regWEN, 1'b0);
        chk1("rst_load", load, 1'b0);
        chk("rst_rd_mem", 32'(rd_mem), 32'd0);
        chk("rst_rd_mem_data", rd_mem_data, 32'd0);
        chk1("rst_ren", dbus_ren, 1'b0);
        chk1("rst_wen", dbus_wen, 1'b0);
        chk("rst_addr", dbus_addr, 32'd0);
        chk("rst_wdata", dbus_wdata, 32'd0);
        chk("rst_be", 32'(dbus_byte_en), 32'd0);
        chk1("rst_mis", misaligned, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk_wb("rst", 1'b0);
        tick();
        nRST = 1'b1;

        // Single-transaction vectors, bus always ready
        for (int i = 0; i < 15; i++) begin
            tick();
            drive(1'b1, vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].st, vecs[i].f3,
                  vecs[i].alu, vecs[i].sd);
            tick();
            drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            dbus_rdata = vecs[i].rdata;
            sample();
            chk1($sformatf("v%0d_stall", i), mem_stall, 1'b0);
            chk1($sformatf("v%0d_regWEN", i), regWEN, vecs[i].rw);
            chk1($sformatf("v%0d_load", i), load, vecs[i].ld);
            chk($sformatf("v%0d_rd_mem", i), 32'(rd_mem), 32'(vecs[i].rd));
            chk($sformatf("v%0d_rd_mem_data", i), rd_mem_data, vecs[i].alu);
            chk1($sformatf("v%0d_ren", i), dbus_ren, vecs[i].e_ren);
            chk1($sformatf("v%0d_wen", i), dbus_wen, vecs[i].e_wen);
            chk($sformatf("v%0d_addr", i), dbus_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_wdata", i), dbus_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_be", i), 32'(dbus_byte_en), 32'(vecs[i].e_be));
            tick();
            sample();
            if (vecs[i].e_wb) begin
                m_rd = vecs[i].rd;
                m_data = vecs[i].e_wbd;
            end
            chk_wb($sformatf("v%0d", i), vecs[i].e_wb);
            chk1($sformatf("v%0d_mis", i), misaligned, vecs[i].e_mis);
            chk1($sformatf("v%0d_bus_err", i), bus_err, 1'b0);
        end

        // LB with three busy cycles; an ADD waits behind it
        tick();
        drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0);
        tick();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'd0);
        dbus_busy = 1'b1;
        dbus_rdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk1($sformatf("lb_busy%0d_ren", i), dbus_ren, 1'b1);
            chk1($sformatf("lb_busy%0d_stall", i), mem_stall, 1'b1);
            chk($sformatf("lb_busy%0d_rd_mem", i), 32'(rd_mem), 32'd3);
            chk($sformatf("lb_busy%0d_be", i), 32'(dbus_byte_en), 32'h8);
            chk($sformatf("lb_busy%0d_addr", i), dbus_addr, 32'h0000_0100);
            chk1($sformatf("lb_busy%0d_wb_we", i), wb_we, 1'b0);
            tick();
        end
        dbus_busy = 1'b0;
        dbus_rdata = 32'h8000_0000;
        sample();
        chk1("lb_done_ren", dbus_ren, 1'b1);
        chk1("lb_done_stall", mem_stall, 1'b0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        sample();
        m_rd = 5'd3;
        m_data = 32'hFFFF_FF80;
        chk_wb("lb_ret", 1'b1);
        chk1("lb_ret_ren", dbus_ren, 1'b0);
        chk("lb_ret_rd_mem", 32'(rd_mem), 32'd9);
        chk("lb_ret_rd_mem_data", rd_mem_data, 32'h0000_0077);
        tick();
        sample();
        m_rd = 5'd9;
        m_data = 32'h0000_0077;
        chk_wb("add_after_lb", 1'b1);

        // LW with the bus stuck busy: timeout after four WAIT cycles
        tick();
        drive(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        dbus_busy = 1'b1;
        sample();
        chk1("to_idle_ren", dbus_ren, 1'b1);
        chk1("to_idle_stall", mem_stall, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            sample();
            chk1($sformatf("to_wait%0d_ren", i), dbus_ren, 1'b1);
            chk1($sformatf("to_wait%0d_stall", i), mem_stall, (i < 3) ? 1'b1 : 1'b0);
            chk1($sformatf("to_wait%0d_bus_err", i), bus_err, 1'b0);
            tick();
        end
        sample();
        chk1("to_bus_err", bus_err, 1'b1);
        chk1("to_ren_drop", dbus_ren, 1'b0);
        chk1("to_stall", mem_stall, 1'b0);
        chk_wb("to", 1'b0);
        tick();
        sample();
        chk1("to_bus_err_pulse", bus_err, 1'b0);
        dbus_busy = 1'b0;

        // LHU flushed in WAIT: drain, no writeback, then two ADDs back to back
        tick();
        drive(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0602, 32'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        dbus_busy = 1'b1;
        sample();
        chk1("dr_idle_ren", dbus_ren, 1'b1);
        chk("dr_idle_be", 32'(dbus_byte_en), 32'hC);
        tick();
        flush = 1'b1;
        sample();
        chk1("dr_flush_stall", mem_stall, 1'b1);
        tick();
        flush = 1'b0;
        sample();
        chk1("dr_ren_held", dbus_ren, 1'b1);
        chk1("dr_stall", mem_stall, 1'b1);
        chk1("dr_regWEN", regWEN, 1'b0);
        chk1("dr_load", load, 1'b0);
        tick();
        dbus_busy = 1'b0;
        dbus_rdata = 32'h1111_2222;
        drive(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_00AA, 32'd0);
        sample();
        chk1("dr_done_stall", mem_stall, 1'b1);
        chk1("dr_done_ren", dbus_ren, 1'b1);
        tick();
        sample();
        chk1("dr_exit_ren", dbus_ren, 1'b0);
        chk1("dr_exit_stall", mem_stall, 1'b0);
        chk1("dr_exit_regWEN", regWEN, 1'b0);
        chk1("dr_exit_bus_err", bus_err, 1'b0);
        chk_wb("dr_exit", 1'b0);
        tick();
        drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_00BB, 32'd0);
        sample();
        chk1("b2b_regWEN", regWEN, 1'b1);
        chk("b2b_rd_mem", 32'(rd_mem), 32'd10);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        sample();
        m_rd = 5'd10;
        m_data = 32'h0000_00AA;
        chk_wb("b2b_first", 1'b1);
        chk("b2b_rd_mem2", 32'(rd_mem), 32'd11);
        tick();
        sample();
        m_rd = 5'd11;
        m_data = 32'h0000_00BB;
        chk_wb("b2b_second", 1'b1);

        // ADD flushed while held: no writeback
        tick();
        drive(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_00CC, 32'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        flush = 1'b1;
        sample();
        chk1("fl_regWEN", regWEN, 1'b1);
        tick();
        flush = 1'b0;
        sample();
        chk_wb("fl", 1'b0);
        chk1("fl_regWEN_after", regWEN, 1'b0);

        // Asynchronous reset in the middle of a WAIT
        tick();
        drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        dbus_busy = 1'b1;
        tick();
        tick();
        sample();
        chk1("ar_pre_ren", dbus_ren, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        chk1("ar_ren", dbus_ren, 1'b0);
        chk1("ar_stall", mem_stall, 1'b0);
        chk1("ar_regWEN", regWEN, 1'b0);
        tick();
        dbus_busy = 1'b0;
        sample();
        m_rd = 5'd0;
        m_data = 32'd0;
        chk_wb("ar", 1'b0);
        chk1("ar_bus_err", bus_err, 1'b0);
        tick();
        nRST = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
